axis_pkt_monitor: RTL and testbench
===================================

// Module: axis_pkt_monitor
// PURPOSE
//  Sink/checker for the 64-bit packet stream produced by the pcap replay source.
//  - Drives ready with optional pseudo-random backpressure.
//  - Checks sop/eop/strb framing and counts packets, bytes and errors.
//  - Records min/max/last packet length for testbench scoreboarding.
// PARAMETERS
//  AXIS_WIDTH     64      data width in bits; multiple of 8
//  CNT_WIDTH      32      width of pkt_count, byte_count and err_count
//  LEN_WIDTH      16      width of the length registers
//  MAX_PKT_BYTES  9600    longest legal packet; longer packets raise OVERSIZE
//  LFSR_SEED      16'hACE1  reset value of the backpressure LFSR; must be non-zero
// PORTS
//  clk         in   1             single clock, all logic on posedge
//  rst         in   1             synchronous, active-high reset
//  data        in   AXIS_WIDTH    beat payload; byte k = data[8k+:8]
//  strb        in   AXIS_WIDTH/8  byte enables; bit k qualifies byte k
//  valid       in   1             beat present
//  sop         in   1             first beat of a packet
//  eop         in   1             last beat of a packet
//  ready       out  1             registered; a beat is accepted when valid&&ready
//  bp_level    in   4             backpressure strength; 0 = ready held high
//  clear       in   1             synchronous clear of counters and flags
//  pkt_done    out  1             one-cycle pulse when a packet's stats update
//  pkt_count   out  CNT_WIDTH     good and bad packets closed by eop
//  byte_count  out  CNT_WIDTH     accepted bytes in good packets
//  err_count   out  CNT_WIDTH     beats carrying at least one error
//  err_flags   out  4             sticky {OVERSIZE,STRB_ERR,DATA_NO_SOP,SOP_IN_PKT}
//  last_len    out  LEN_WIDTH     length in bytes of the last closed packet
//  min_len     out  LEN_WIDTH     shortest good packet
//  max_len     out  LEN_WIDTH     longest good packet
// BEHAVIOUR
//  Reset values:
//  - ready=0, pkt_done=0, all counters=0, err_flags=0, last_len=0.
//  - min_len=all-ones, max_len=0, LFSR=LFSR_SEED, state=IDLE.
//  Backpressure:
//  - 16-bit Fibonacci LFSR, taps 16,14,13,11; steps every cycle when not in rst.
//  - Next-cycle ready = (bp_level==0) | (lfsr[3:0] >= bp_level).
//  - Input stability while valid&&!ready is not required; only accepted beats count.
//  Beat byte count:
//  - Bytes per beat = popcount(strb).
//  - Legal strb is contiguous ones from bit 0.
//  - Non-eop beats must be all ones; eop beats must be non-zero and contiguous.
//  - Any other strb sets STRB_ERR.
//  FSM IDLE/IN_PKT, evaluated on accepted beats only:
//  - IDLE, sop&!eop: acc_len=bytes, go IN_PKT.
//  - IDLE, sop&eop: close the packet immediately with len=bytes.
//  - IDLE, !sop: set DATA_NO_SOP; discard the beat; stay IDLE; no pkt_count change.
//  - IN_PKT, !sop&!eop: acc_len += bytes.
//  - IN_PKT, !sop&eop: close with len=acc_len+bytes; go IDLE.
//  - IN_PKT, sop: set SOP_IN_PKT; close the old packet as bad (pkt_count+1,
//    no byte/len update). The new beat then starts a packet as in IDLE.
//  Length rules:
//  - acc_len saturates at all-ones.
//  - len > MAX_PKT_BYTES sets OVERSIZE and marks the packet bad.
//  Close of a packet:
//  - Stats update and pkt_done pulse in the cycle after the eop beat is accepted
//    (latency 1).
//  - pkt_count+1 and last_len=len on every close.
//  - Good packets only: byte_count+=len, min_len/max_len updated.
//  - Bad = any error flagged on any of the packet's beats.
//  Error counting:
//  - err_count +1 per accepted beat with one or more errors (not once per error).
//  - err_flags bits are sticky until rst or clear.
//  Wrap and saturation:
//  - CNT_WIDTH counters wrap modulo 2^CNT_WIDTH.
//  - Length registers saturate.
//  clear:
//  - Same reset values as rst for counters, flags and lengths; FSM forced to IDLE.
//  - LFSR and ready are untouched.
//  - clear coincident with a close: clear wins; the packet is not counted.
//  rst mid-packet: partial packet dropped, nothing counted.
// TESTING
//  1. bp_level=0; 60-byte pkt (7 full beats + eop strb=8'h0F)
//     -> pkt_count=1, byte_count=60, min=max=last=60, pkt_done 1 cycle after eop.
//  2. bp_level=8; 100 random pkts of 64..1518 B
//     -> byte_count = sum of lengths, err_count=0, ready duty ~50%.
//  3. sop twice without eop, then eop
//     -> SOP_IN_PKT set, err_count=1, pkt_count=2, byte_count = second pkt only.
//  4. Beat with valid, no sop, in IDLE -> DATA_NO_SOP, err_count=1, pkt_count=0.
//     Non-eop beat with strb=8'h7F -> STRB_ERR, packet excluded from min/max.
//  5. MAX_PKT_BYTES=1518; 1600-B pkt
//     -> OVERSIZE, pkt_count=1, byte_count=0, last_len=1600.
//  6. clear on the eop-close cycle -> all counters 0, pkt_done suppressed.
//     rst mid-packet -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/axis_pkt_monitor.sv
// axis_pkt_monitor: sink and framing checker for the 64-bit packet replay stream.
// Generates LFSR backpressure, validates sop/eop/strb framing and keeps packet statistics.
module axis_pkt_monitor #(
    parameter int unsigned AXIS_WIDTH    = 64,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned LEN_WIDTH     = 16,
    parameter int unsigned MAX_PKT_BYTES = 9600,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXIS_WIDTH-1:0]   data,
    input  logic [AXIS_WIDTH/8-1:0] strb,
    input  logic                    valid,
    input  logic                    sop,
    input  logic                    eop,
    output logic                    ready,
    input  logic [3:0]              bp_level,
    input  logic                    clear,
    output logic                    pkt_done,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]    byte_count,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic [3:0]              err_flags,
    output logic [LEN_WIDTH-1:0]    last_len,
    output logic [LEN_WIDTH-1:0]    min_len,
    output logic [LEN_WIDTH-1:0]    max_len
);

    localparam int unsigned STRB_WIDTH  = AXIS_WIDTH / 8;
    localparam int unsigned BYTES_WIDTH = $clog2(STRB_WIDTH + 1);
    localparam int unsigned LEN_WIDE    = LEN_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = {LEN_WIDTH{1'b1}};

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] IN_PKT = 1'b1;

    logic [0:0]             state;
    logic [0:0]             state_nxt;
    logic [LEN_WIDTH-1:0]   acc_len;
    logic [LEN_WIDTH-1:0]   acc_nxt;
    logic                   pkt_bad;
    logic                   bad_nxt;

    logic [15:0]            lfsr;
    logic                   lfsr_fb;

    logic                   accept;
    logic [BYTES_WIDTH-1:0] beat_bytes;
    logic [LEN_WIDTH-1:0]   beat_len;
    logic                   strb_contig;
    logic                   strb_bad;
    logic [LEN_WIDE-1:0]    sum_wide;
    logic [LEN_WIDTH-1:0]   sum_len;

    logic                   err_strb;
    logic                   err_no_sop;
    logic                   err_sop_in_pkt;
    logic                   err_oversize;
    logic                   beat_err;
    logic                   abandon;
    logic                   close;
    logic                   close_good;
    logic [LEN_WIDTH-1:0]   close_len;

    // The payload itself is not inspected; only framing and byte enables matter.
    logic unused_data;
    assign unused_data = ^data;

    assign accept = valid && ready;

    // Fibonacci LFSR, taps 16,14,13,11; drives next-cycle ready.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= LFSR_SEED;
            ready <= 1'b0;
        end else begin
            lfsr  <= {lfsr[14:0], lfsr_fb};
            ready <= (bp_level == 4'd0) || (lfsr[3:0] >= bp_level);
        end
    end

    // Byte count of the current beat.
    always_comb begin
        beat_bytes = '0;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            beat_bytes = beat_bytes + BYTES_WIDTH'(strb[k]);
        end
    end

    assign beat_len    = LEN_WIDTH'(beat_bytes);
    assign strb_contig = ((strb & (strb + STRB_WIDTH'(1))) == '0);
    assign strb_bad    = eop ? ((strb == '0) || !strb_contig) : !(&strb);

    // Saturating running length.
    assign sum_wide = {1'b0, acc_len} + LEN_WIDE'(beat_bytes);
    assign sum_len  = sum_wide[LEN_WIDTH] ? LEN_MAX : sum_wide[LEN_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state   <= IDLE;
            acc_len <= '0;
            pkt_bad <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc_len <= acc_nxt;
            pkt_bad <= bad_nxt;
        end
    end

    // Framing FSM; only accepted beats advance it.
    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc_len;
        bad_nxt        = pkt_bad;
        err_strb       = 1'b0;
        err_no_sop     = 1'b0;
        err_sop_in_pkt = 1'b0;
        err_oversize   = 1'b0;
        abandon        = 1'b0;
        close          = 1'b0;
        close_good     = 1'b0;
        close_len      = '0;

        if (accept) begin
            err_strb = strb_bad;
            if (state == IN_PKT && sop) begin
                err_sop_in_pkt = 1'b1;
                abandon        = 1'b1;
            end

            if (sop) begin
                if (eop) begin
                    close        = 1'b1;
                    close_len    = beat_len;
                    err_oversize = (32'(beat_len) > MAX_PKT_BYTES);
                    close_good   = !strb_bad && !err_oversize;
                    state_nxt    = IDLE;
                end else begin
                    acc_nxt   = beat_len;
                    bad_nxt   = strb_bad;
                    state_nxt = IN_PKT;
                end
            end else if (state == IDLE) begin
                err_no_sop = 1'b1;
            end else if (eop) begin
                close        = 1'b1;
                close_len    = sum_len;
                err_oversize = (32'(sum_len) > MAX_PKT_BYTES);
                close_good   = !pkt_bad && !strb_bad && !err_oversize;
                state_nxt    = IDLE;
            end else begin
                acc_nxt = sum_len;
                bad_nxt = pkt_bad || strb_bad;
            end
        end
    end

    assign beat_err = err_strb || err_no_sop || err_sop_in_pkt || err_oversize;

    // Statistics; an abandoned packet counts but leaves lengths and bytes alone.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pkt_done   <= 1'b0;
            pkt_count  <= '0;
            byte_count <= '0;
            err_count  <= '0;
            err_flags  <= '0;
            last_len   <= '0;
            min_len    <= LEN_MAX;
            max_len    <= '0;
        end else begin
            pkt_done  <= abandon || close;
            pkt_count <= pkt_count + CNT_WIDTH'(abandon) + CNT_WIDTH'(close);
            err_flags <= err_flags | {err_oversize, err_strb, err_no_sop, err_sop_in_pkt};
            if (beat_err) begin
                err_count <= err_count + CNT_WIDTH'(1);
            end
            if (close) begin
                last_len <= close_len;
            end
            if (close && close_good) begin
                byte_count <= byte_count + CNT_WIDTH'(close_len);
                if (close_len < min_len) begin
                    min_len <= close_len;
                end
                if (close_len > max_len) begin
                    max_len <= close_len;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_monitor.sv
// tb_axis_pkt_monitor: directed checks of framing, statistics, clear and reset
// for axis_pkt_monitor with MAX_PKT_BYTES set to 1518.
module tb_axis_pkt_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        valid;
    logic        sop;
    logic        eop;
    logic        ready;
    logic [3:0]  bp_level;
    logic        clear;
    logic        pkt_done;
    logic [31:0] pkt_count;
    logic [31:0] byte_count;
    logic [31:0] err_count;
    logic [3:0]  err_flags;
    logic [15:0] last_len;
    logic [15:0] min_len;
    logic [15:0] max_len;

    int n_checks = 0;
    int n_errors = 0;
    bit meas     = 1'b0;
    int meas_cyc = 0;
    int meas_rdy = 0;

    axis_pkt_monitor #(
        .AXIS_WIDTH    (64),
        .CNT_WIDTH     (32),
        .LEN_WIDTH     (16),
        .MAX_PKT_BYTES (1518),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .strb       (strb),
        .valid      (valid),
        .sop        (sop),
        .eop        (eop),
        .ready      (ready),
        .bp_level   (bp_level),
        .clear      (clear),
        .pkt_done   (pkt_done),
        .pkt_count  (pkt_count),
        .byte_count (byte_count),
        .err_count  (err_count),
        .err_flags  (err_flags),
        .last_len   (last_len),
        .min_len    (min_len),
        .max_len    (max_len)
    );

    always #5 clk = ~clk;

    // Ready duty measurement, sampled mid-cycle.
    always @(negedge clk) begin
        if (meas) begin
            meas_cyc++;
            if (ready) meas_rdy++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Entered and left just after a rising edge; returns after the beat is accepted.
    task automatic send_beat(input logic s, input logic e, input logic [7:0] st);
        int n;
        n     = 0;
        valid = 1'b1;
        sop   = s;
        eop   = e;
        strb  = st;
        data  = {$urandom, $urandom};
        while (!ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) check_eq("ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
        strb  = 8'h00;
    endtask

    task automatic send_pkt(input int len);
        int nb;
        nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            logic [7:0] st;
            int rem;
            st = 8'hFF;
            if (b == nb - 1) begin
                rem = len - 8 * b;
                st  = 8'((1 << rem) - 1);
            end
            send_beat(b == 0, b == nb - 1, st);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int len;
        int sum;
        int mn;
        int mx;
        int duty;

        rst      = 1'b1;
        data     = '0;
        strb     = '0;
        valid    = 1'b0;
        sop      = 1'b0;
        eop      = 1'b0;
        bp_level = 4'd0;
        clear    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_pkt_done", 32'(pkt_done), 32'd0);
        check_eq("rst_pkt_count", pkt_count, 32'd0);
        check_eq("rst_min_len", 32'(min_len), 32'hFFFF);
        check_eq("rst_max_len", 32'(max_len), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: single 60-byte packet, no backpressure
        for (int b = 0; b < 7; b++) send_beat(b == 0, 1'b0, 8'hFF);
        check_eq("t1_no_done_before_eop", 32'(pkt_done), 32'd0);
        send_beat(1'b0, 1'b1, 8'h0F);
        check_eq("t1_pkt_done", 32'(pkt_done), 32'd1);
        check_eq("t1_pkt_count", pkt_count, 32'd1);
        check_eq("t1_byte_count", byte_count, 32'd60);
        check_eq("t1_min_len", 32'(min_len), 32'd60);
        check_eq("t1_max_len", 32'(max_len), 32'd60);
        check_eq("t1_last_len", 32'(last_len), 32'd60);
        check_eq("t1_err_count", err_count, 32'd0);
        @(posedge clk);
        #1;
        check_eq("t1_done_one_cycle", 32'(pkt_done), 32'd0);

        // 2: 100 packets of 64..1518 bytes with bp_level=8
        do_clear();
        bp_level = 4'd8;
        sum = 0;
        mn  = 65535;
        mx  = 0;
        meas = 1'b1;
        for (int i = 0; i < 100; i++) begin
            len = 64 + ((i * 389 + 17) % 1455);
            if (i == 3) len = 64;
            if (i == 7) len = 1518;
            sum += len;
            if (len < mn) mn = len;
            if (len > mx) mx = len;
            send_pkt(len);
        end
        meas = 1'b0;
        check_eq("t2_pkt_count", pkt_count, 32'd100);
        check_eq("t2_byte_count", byte_count, 32'(sum));
        check_eq("t2_err_count", err_count, 32'd0);
        check_eq("t2_min_len", 32'(min_len), 32'(mn));
        check_eq("t2_max_len", 32'(max_len), 32'(mx));
        duty = (meas_cyc > 0) ? (meas_rdy * 100) / meas_cyc : 0;
        check_eq("t2_ready_duty_35_65", 32'(duty >= 35 && duty <= 65), 32'd1);
        bp_level = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        // 3: sop inside a packet abandons it; the new packet is good
        do_clear();
        send_beat(1'b1, 1'b0, 8'hFF);
        send_beat(1'b0, 1'b0, 8'hFF);
        send_beat(1'b1, 1'b0, 8'hFF);
        check_eq("t3_abandon_done", 32'(pkt_done), 32'd1);
        check_eq("t3_abandon_count", pkt_count, 32'd1);
        check_eq("t3_abandon_last_len", 32'(last_len), 32'd0);
        send_beat(1'b0, 1'b1, 8'h07);
        check_eq("t3_pkt_count", pkt_count, 32'd2);
        check_eq("t3_byte_count", byte_count, 32'd11);
        check_eq("t3_err_count", err_count, 32'd1);
        check_eq("t3_err_flags", 32'(err_flags), 32'h1);
        check_eq("t3_min_len", 32'(min_len), 32'd11);

        // 4a: data beat without sop in IDLE
        do_clear();
        send_beat(1'b0, 1'b0, 8'hFF);
        check_eq("t4a_err_flags", 32'(err_flags), 32'h2);
        check_eq("t4a_err_count", err_count, 32'd1);
        check_eq("t4a_pkt_count", pkt_count, 32'd0);
        check_eq("t4a_pkt_done", 32'(pkt_done), 32'd0);

        // 4b: partial strb on a non-eop beat makes the packet bad
        do_clear();
        send_beat(1'b1, 1'b0, 8'hFF);
        send_beat(1'b0, 1'b0, 8'h7F);
        send_beat(1'b0, 1'b1, 8'h0F);
        check_eq("t4b_err_flags", 32'(err_flags), 32'h4);
        check_eq("t4b_err_count", err_count, 32'd1);
        check_eq("t4b_pkt_count", pkt_count, 32'd1);
        check_eq("t4b_byte_count", byte_count, 32'd0);
        check_eq("t4b_last_len", 32'(last_len), 32'd19);
        check_eq("t4b_min_len", 32'(min_len), 32'hFFFF);
        check_eq("t4b_max_len", 32'(max_len), 32'd0);
        send_beat(1'b1, 1'b1, 8'h03);
        check_eq("t4b_good_min", 32'(min_len), 32'd2);
        check_eq("t4b_good_bytes", byte_count, 32'd2);

        // 5: oversize packet
        do_clear();
        send_pkt(1600);
        check_eq("t5_err_flags", 32'(err_flags), 32'h8);
        check_eq("t5_pkt_count", pkt_count, 32'd1);
        check_eq("t5_byte_count", byte_count, 32'd0);
        check_eq("t5_last_len", 32'(last_len), 32'd1600);
        check_eq("t5_err_count", err_count, 32'd1);

        // 6a: clear coincident with the eop beat wins
        do_clear();
        send_beat(1'b1, 1'b0, 8'hFF);
        clear = 1'b1;
        send_beat(1'b0, 1'b1, 8'hFF);
        clear = 1'b0;
        check_eq("t6a_pkt_done", 32'(pkt_done), 32'd0);
        check_eq("t6a_pkt_count", pkt_count, 32'd0);
        check_eq("t6a_byte_count", byte_count, 32'd0);
        check_eq("t6a_ready_kept", 32'(ready), 32'd1);
        send_beat(1'b0, 1'b1, 8'hFF);
        check_eq("t6a_fsm_idle", 32'(err_flags), 32'h2);
        check_eq("t6a_pkt_count_after", pkt_count, 32'd0);

        // 6b: reset mid-packet drops everything
        do_clear();
        send_pkt(8);
        check_eq("t6b_pre_count", pkt_count, 32'd1);
        send_beat(1'b1, 1'b0, 8'hFF);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("t6b_ready", 32'(ready), 32'd0);
        check_eq("t6b_pkt_count", pkt_count, 32'd0);
        check_eq("t6b_byte_count", byte_count, 32'd0);
        check_eq("t6b_err_flags", 32'(err_flags), 32'd0);
        check_eq("t6b_last_len", 32'(last_len), 32'd0);
        check_eq("t6b_min_len", 32'(min_len), 32'hFFFF);
        send_beat(1'b0, 1'b1, 8'hFF);
        check_eq("t6b_idle_after_rst", 32'(err_flags), 32'h2);
        check_eq("t6b_no_close", pkt_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
